// File: rtl/rv_instr_loader_pkg.sv
// Shared RV32I definitions for the instruction loader: opcodes, NOP encoding,
// FSM state type and the immediate range check used by the encoder.
package rv_instr_loader_pkg;

    localparam logic [6:0]  R_TYPE    = 7'h33;
    localparam logic [6:0]  I_TYPE    = 7'h13;
    localparam logic [6:0]  S_TYPE    = 7'h23;
    localparam logic [6:0]  B_TYPE    = 7'h63;
    localparam logic [6:0]  U_TYPE    = 7'h37;
    localparam logic [6:0]  J_TYPE    = 7'h6F;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    // True when imm[31:msb] are all copies of the sign bit, i.e. the value
    // survives truncation to msb+1 bits and re-extension by the decoder.
    function automatic logic sext_fits(input logic [31:0] imm, input int msb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= msb && imm[i] != imm[31]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/rv_instr_loader_encode.sv
// Combinational RV32I packer: exact inverse of the decoder's field extraction,
// plus a legality flag for unknown opcodes and out-of-range immediates.
module rv_encode_instr
    import rv_instr_loader_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        legal_o
);

    always_comb begin
        instr_o = NOP_INSTR;
        legal_o = 1'b0;
        case (opcode_i)
            R_TYPE: begin
                instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
                legal_o = 1'b1;
            end
            I_TYPE: begin
                instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                legal_o = sext_fits(imm_i, 11);
            end
            S_TYPE: begin
                instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                legal_o = sext_fits(imm_i, 11);
            end
            B_TYPE: begin
                instr_o = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i,
                           imm_i[3:0], imm_i[10], opcode_i};
                legal_o = sext_fits(imm_i, 11);
            end
            U_TYPE: begin
                instr_o = {imm_i[19:0], rd_i, opcode_i};
                legal_o = sext_fits(imm_i, 19);
            end
            J_TYPE: begin
                instr_o = {imm_i[19], imm_i[9:0], imm_i[10], imm_i[18:11], rd_i, opcode_i};
                legal_o = sext_fits(imm_i, 19);
            end
            default: begin
                instr_o = NOP_INSTR;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv_instr_loader.sv
// IMEM loader: accepts decoded fields, encodes them and writes consecutive words
// through a single output register stage with write backpressure.
module rv_instr_loader
    import rv_instr_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [LEN_W-1:0]  err_cnt_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [LEN_W-1:0]  unissued_q;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [31:0]       data_p1;
    logic              err_q;
    logic [LEN_W-1:0]  err_cnt_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic [31:0]       enc_instr_p0;
    logic              enc_legal_p0;
    logic              accept_p0;
    logic              wr_hs;
    logic [ADDR_W-1:0] base_aligned;

    rv_encode_instr u_encode (
        .opcode_i (opcode_i),
        .rd_i     (rd_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .funct3_i (funct3_i),
        .funct7_i (funct7_i),
        .imm_i    (imm_i),
        .instr_o  (enc_instr_p0),
        .legal_o  (enc_legal_p0)
    );

    assign base_aligned = base_addr_i & ~ADDR_W'(3);
    assign wr_hs        = vld_p1 && mem_ready_i;
    assign in_ready_o   = (state_q == ST_LOAD) && (unissued_q != '0) && (!vld_p1 || mem_ready_i);
    assign accept_p0    = in_valid_i && in_ready_o;

    // Stage p0 -> p1: accepted item is encoded and captured into the write register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            unissued_q  <= '0;
            vld_p1      <= 1'b0;
            addr_p1     <= '0;
            data_p1     <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        addr_q      <= base_aligned;
                        remaining_q <= len_i;
                        unissued_q  <= len_i;
                        err_q       <= 1'b0;
                        err_cnt_q   <= '0;
                        err_addr_q  <= '0;
                        state_q     <= (len_i == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept_p0) begin
                        vld_p1     <= 1'b1;
                        addr_p1    <= addr_q;
                        data_p1    <= enc_legal_p0 ? enc_instr_p0 : NOP_INSTR;
                        addr_q     <= addr_q + ADDR_W'(4);
                        unissued_q <= unissued_q - LEN_W'(1);
                        if (!enc_legal_p0) begin
                            err_q <= 1'b1;
                            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + LEN_W'(1);
                            if (!err_q) err_addr_q <= addr_q;
                        end
                    end else if (wr_hs) begin
                        vld_p1 <= 1'b0;
                    end
                    if (wr_hs) begin
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_we_o    = vld_p1;
    assign mem_addr_o  = addr_p1;
    assign mem_wdata_o = data_p1;
    assign busy_o      = (state_q == ST_LOAD);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;
    assign err_addr_o  = err_addr_q;

endmodule
